// File: rtl/jpeg_stream_seq_pkg.sv
// Shared constants and FSM state type for the JPEG row stream sequencer.
package jpeg_seq_pkg;

    localparam int ROWS_PER_BLOCK = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } seq_state_e;

endpackage

// File: rtl/jpeg_stream_seq_if.sv
// Row read/write stream bundle between the sequencer (master) and the
// frame buffer / DCT pipeline (slave).
interface jpeg_seq_if #(
    parameter int ADDR_W = 15
);

    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [2:0]        phase;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        output rd_valid, rd_addr, phase, wr_valid, wr_addr
    );

    modport slave (
        input rd_valid, rd_addr, phase, wr_valid, wr_addr
    );

endinterface

// File: rtl/jpeg_stream_seq_addr_gen.sv
// Block-raster row counter with address mapping; row-major image layout when
// JPEG_SEQ_RASTER_ADDR_EN is defined, block-major linear addressing otherwise.
module jpeg_addr_gen
    import jpeg_seq_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int IMG_BLOCKS_X = 8,
    parameter int IMG_BLOCKS_Y = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              advance_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    localparam int N_ROWS = IMG_BLOCKS_X * IMG_BLOCKS_Y * ROWS_PER_BLOCK;
    localparam int CNT_W  = $clog2(N_ROWS + 1);

    logic [CNT_W-1:0] cnt_q;

    assign last_o = (cnt_q == CNT_W'(N_ROWS - 1));

    // Row count wraps to zero after the last row so the next frame starts clean.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt_q <= '0;
        end else if (advance_i) begin
            cnt_q <= last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

`ifdef JPEG_SEQ_RASTER_ADDR_EN
    localparam int BX_W = (IMG_BLOCKS_X > 1) ? $clog2(IMG_BLOCKS_X) : 1;
    localparam int BY_W = (IMG_BLOCKS_Y > 1) ? $clog2(IMG_BLOCKS_Y) : 1;

    logic [BX_W-1:0] bx_q;
    logic [BY_W-1:0] by_q;
    logic            blockEnd;

    assign blockEnd = (cnt_q[2:0] == 3'd7);

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            bx_q <= '0;
            by_q <= '0;
        end else if (advance_i && blockEnd) begin
            if (bx_q == BX_W'(IMG_BLOCKS_X - 1)) begin
                bx_q <= '0;
                by_q <= (by_q == BY_W'(IMG_BLOCKS_Y - 1)) ? '0 : by_q + BY_W'(1);
            end else begin
                bx_q <= bx_q + BX_W'(1);
            end
        end
    end

    // Pixel row (by*8 + row) times the image width in words, plus the block column.
    assign addr_o = ADDR_W'((int'(by_q) * ROWS_PER_BLOCK + int'(cnt_q[2:0])) * IMG_BLOCKS_X
                            + int'(bx_q));
`else
    assign addr_o = ADDR_W'(cnt_q);
`endif

endmodule

// File: rtl/jpeg_stream_seq.sv
// Frame sequencer for the row-based DCT/quant/IDCT pipeline: issues source row
// reads, tracks pipeline latency and emits write addresses. Address layout is
// selected by JPEG_SEQ_RASTER_ADDR_EN (see jpeg_addr_gen).
module jpeg_stream_seq
    import jpeg_seq_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int IMG_BLOCKS_X = 8,
    parameter int IMG_BLOCKS_Y = 8,
    parameter int PIPE_LAT     = 33
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    output logic        pipe_en,
    output logic        busy,
    output logic        done,
    jpeg_seq_if.master  bus
);

    seq_state_e          state_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          phase_q;
    logic [PIPE_LAT-1:0] validSr_q;
    logic [PIPE_LAT-1:0] validSr_d;

    logic              rdFire;
    logic              wrFire;
    logic              rdLast;
    logic              wrLast;
    logic              frameStart;
    logic [ADDR_W-1:0] rdAddr;
    logic [ADDR_W-1:0] wrAddr;

    assign pipe_en    = busy_q && !stall;
    assign rdFire     = (state_q == RUN) && !stall;
    assign wrFire     = validSr_q[PIPE_LAT-1] && pipe_en;
    assign frameStart = (state_q == IDLE) && start;
    assign validSr_d  = (validSr_q << 1) | PIPE_LAT'(rdFire);

    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.rd_valid = rdFire;
    assign bus.rd_addr  = rdAddr;
    assign bus.phase    = phase_q;
    assign bus.wr_valid = wrFire;
    assign bus.wr_addr  = wrAddr;

    jpeg_addr_gen #(
        .ADDR_W       (ADDR_W),
        .IMG_BLOCKS_X (IMG_BLOCKS_X),
        .IMG_BLOCKS_Y (IMG_BLOCKS_Y)
    ) rdGen (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (frameStart),
        .advance_i (rdFire),
        .addr_o    (rdAddr),
        .last_o    (rdLast)
    );

    jpeg_addr_gen #(
        .ADDR_W       (ADDR_W),
        .IMG_BLOCKS_X (IMG_BLOCKS_X),
        .IMG_BLOCKS_Y (IMG_BLOCKS_Y)
    ) wrGen (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (frameStart),
        .advance_i (wrFire),
        .addr_o    (wrAddr),
        .last_o    (wrLast)
    );

    // Stall freezes everything by withholding rdFire/wrFire/pipe_en; the shift
    // register drains to all-zero by the end of a frame, so no clear on start.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            phase_q   <= '0;
            validSr_q <= '0;
        end else begin
            if (pipe_en) begin
                validSr_q <= validSr_d;
            end
            if (rdFire) begin
                phase_q <= phase_q + 3'd1;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        phase_q <= '0;
                    end
                end
                RUN: begin
                    if (rdFire && rdLast) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wrFire && wrLast) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jpeg_stream_seq.sv
// Self-checking bench for jpeg_stream_seq: two instances (small frame, narrow
// address wrap) checked each cycle against a frame-level model plus literals.
module tb_jpeg_stream_seq;

    localparam int AW0 = 15, X0 = 2, Y0 = 1, L0 = 4;
    localparam int AW1 = 4,  X1 = 4, Y1 = 1, L1 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstS[2];
    logic startS[2];
    logic stallS[2];

    logic pipeEnA, busyA, doneA, pipeEnB, busyB, doneB;

    jpeg_seq_if #(.ADDR_W(AW0)) busA ();
    jpeg_seq_if #(.ADDR_W(AW1)) busB ();

    jpeg_stream_seq #(
        .ADDR_W(AW0), .IMG_BLOCKS_X(X0), .IMG_BLOCKS_Y(Y0), .PIPE_LAT(L0)
    ) dutA (
        .clk(clk), .reset(rstS[0]), .start(startS[0]), .stall(stallS[0]),
        .pipe_en(pipeEnA), .busy(busyA), .done(doneA), .bus(busA)
    );

    jpeg_stream_seq #(
        .ADDR_W(AW1), .IMG_BLOCKS_X(X1), .IMG_BLOCKS_Y(Y1), .PIPE_LAT(L1)
    ) dutB (
        .clk(clk), .reset(rstS[1]), .start(startS[1]), .stall(stallS[1]),
        .pipe_en(pipeEnB), .busy(busyB), .done(doneB), .bus(busB)
    );

    logic [31:0] aRdAddr[2], aWrAddr[2], aPhase[2];
    logic        aRdV[2], aWrV[2], aBusy[2], aDone[2], aEn[2];

    assign aRdAddr[0] = 32'(busA.rd_addr);
    assign aRdAddr[1] = 32'(busB.rd_addr);
    assign aWrAddr[0] = 32'(busA.wr_addr);
    assign aWrAddr[1] = 32'(busB.wr_addr);
    assign aPhase[0]  = 32'(busA.phase);
    assign aPhase[1]  = 32'(busB.phase);
    assign aRdV[0]    = busA.rd_valid;
    assign aRdV[1]    = busB.rd_valid;
    assign aWrV[0]    = busA.wr_valid;
    assign aWrV[1]    = busB.wr_valid;
    assign aBusy[0]   = busyA;
    assign aBusy[1]   = busyB;
    assign aDone[0]   = doneA;
    assign aDone[1]   = doneB;
    assign aEn[0]     = pipeEnA;
    assign aEn[1]     = pipeEnB;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame-level model: e counts enabled cycles since start; row i is read at e=i
    // and written at e=i+LAT; the frame lasts N+LAT enabled cycles.
    int mE[2];
    bit mBusy[2], mDone[2], mAfterReset[2], mValid[2];

    int rdLogA[$], rdLogB[$];
    int firstRd[2], firstWr[2], lastWr[2], doneCyc[2], busyCnt[2], doneCnt[2];

    function automatic int cfgX(input int d);
        return (d == 0) ? X0 : X1;
    endfunction

    function automatic int cfgAW(input int d);
        return (d == 0) ? AW0 : AW1;
    endfunction

    function automatic int cfgLat(input int d);
        return (d == 0) ? L0 : L1;
    endfunction

    function automatic int cfgN(input int d);
        return (d == 0) ? X0 * Y0 * 8 : X1 * Y1 * 8;
    endfunction

    function automatic int addrOf(input int d, input int i);
        int a;
`ifdef JPEG_SEQ_RASTER_ADDR_EN
        int blk, row, bx, by;
        blk = i / 8;
        row = i % 8;
        bx  = blk % cfgX(d);
        by  = blk / cfgX(d);
        a   = (by * 8 + row) * cfgX(d) + bx;
`else
        a = i;
`endif
        return a % (1 << cfgAW(d));
    endfunction

    task automatic checkOutput(input string name, input int d,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d at cycle %0d: got %0d expected %0d",
                     name, d, cyc, act, exp);
        end
    endtask

    // Compare outputs against the model, log observations, then advance the model
    // using the inputs that the coming rising edge will sample.
    always @(negedge clk) begin : cmp
        int  e, n, lat;
        bit  eEn, eRdV, eWrV;
        for (int d = 0; d < 2; d++) begin
            n    = cfgN(d);
            lat  = cfgLat(d);
            e    = mE[d];
            eEn  = mBusy[d] && !stallS[d];
            eRdV = eEn && (e < n);
            eWrV = eEn && (e >= lat) && (e - lat < n);
            if (mValid[d]) begin
                checkOutput("busy", d, 32'(aBusy[d]), 32'(mBusy[d]));
                checkOutput("done", d, 32'(aDone[d]), 32'(mDone[d]));
                checkOutput("pipe_en", d, 32'(aEn[d]), 32'(eEn));
                checkOutput("rd_valid", d, 32'(aRdV[d]), 32'(eRdV));
                checkOutput("wr_valid", d, 32'(aWrV[d]), 32'(eWrV));
                if (mBusy[d] && e < n) begin
                    checkOutput("rd_addr", d, aRdAddr[d], 32'(addrOf(d, e)));
                    checkOutput("phase", d, aPhase[d], 32'(e % 8));
                end
                if (eWrV) begin
                    checkOutput("wr_addr", d, aWrAddr[d], 32'(addrOf(d, e - lat)));
                end
                if (mAfterReset[d]) begin
                    checkOutput("rstRdAddr", d, aRdAddr[d], 32'd0);
                    checkOutput("rstWrAddr", d, aWrAddr[d], 32'd0);
                    checkOutput("rstPhase", d, aPhase[d], 32'd0);
                end
            end
            if (aRdV[d] === 1'b1) begin
                if (d == 0) rdLogA.push_back(int'(aRdAddr[d]));
                else        rdLogB.push_back(int'(aRdAddr[d]));
                if (firstRd[d] < 0) firstRd[d] = cyc;
            end
            if (aWrV[d] === 1'b1) begin
                if (firstWr[d] < 0) firstWr[d] = cyc;
                lastWr[d] = cyc;
            end
            if (aBusy[d] === 1'b1) busyCnt[d]++;
            if (aDone[d] === 1'b1) begin
                doneCnt[d]++;
                doneCyc[d] = cyc;
            end
            if (rstS[d]) begin
                mValid[d]      = 1'b1;
                mBusy[d]       = 1'b0;
                mDone[d]       = 1'b0;
                mE[d]          = 0;
                mAfterReset[d] = 1'b1;
            end else if (mDone[d]) begin
                mDone[d] = 1'b0;
            end else if (!mBusy[d]) begin
                if (startS[d]) begin
                    mBusy[d]       = 1'b1;
                    mE[d]          = 0;
                    mAfterReset[d] = 1'b0;
                end
            end else if (!stallS[d]) begin
                if (e == n + lat - 1) begin
                    mBusy[d] = 1'b0;
                    mDone[d] = 1'b1;
                end else begin
                    mE[d] = e + 1;
                end
            end
        end
    end

    task automatic applyStimulus(input int d, input logic s, input logic st,
                                 input logic r, input int nCycles);
        startS[d] = s;
        stallS[d] = st;
        rstS[d]   = r;
        repeat (nCycles) @(posedge clk);
        #1;
    endtask

    task automatic clearLogs(input int d);
        if (d == 0) rdLogA.delete();
        else        rdLogB.delete();
        firstRd[d] = -1;
        firstWr[d] = -1;
        lastWr[d]  = -1;
        doneCyc[d] = -1;
        busyCnt[d] = 0;
    endtask

    task automatic waitDone(input int d, input int budget);
        int startCnt;
        int k;
        startCnt = doneCnt[d];
        k = 0;
        while (doneCnt[d] == startCnt && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("doneTimeout", d, 32'(doneCnt[d] != startCnt), 32'd1);
    endtask

    int expRd[16];
    int t0;
    int doneBefore;
    int exp15B, exp16B;

    initial begin
        for (int d = 0; d < 2; d++) begin
            rstS[d]   = 1'b1;
            startS[d] = 1'b0;
            stallS[d] = 1'b0;
            doneCnt[d] = 0;
            mValid[d]  = 1'b0;
            clearLogs(d);
        end
`ifdef JPEG_SEQ_RASTER_ADDR_EN
        expRd  = '{0, 2, 4, 6, 8, 10, 12, 14, 1, 3, 5, 7, 9, 11, 13, 15};
        exp15B = 13;
        exp16B = 2;
`else
        expRd  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
        exp15B = 15;
        exp16B = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        rstS[0] = 1'b0;
        rstS[1] = 1'b0;
        @(negedge clk);
        checkOutput("litRstBusy", 0, 32'(busyA), 32'd0);
        checkOutput("litRstDone", 0, 32'(doneA), 32'd0);
        checkOutput("litRstEn", 0, 32'(pipeEnA), 32'd0);
        checkOutput("litRstRdAddr", 0, aRdAddr[0], 32'd0);
        checkOutput("litRstWrV", 1, 32'(aWrV[1]), 32'd0);
        @(posedge clk);
        #1;

        // Frame 1 on A, with a second start pulse while draining.
        clearLogs(0);
        t0 = cyc;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 17);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 1);
        waitDone(0, 60);
        checkOutput("litRdCount", 0, 32'(rdLogA.size()), 32'd16);
        for (int i = 0; i < 16 && i < rdLogA.size(); i++) begin
            checkOutput($sformatf("litRdSeq%0d", i), 0, 32'(rdLogA[i]), 32'(expRd[i]));
        end
        checkOutput("litFirstRd", 0, 32'(firstRd[0] - t0), 32'd1);
        checkOutput("litWrLatency", 0, 32'(firstWr[0] - firstRd[0]), 32'd4);
        checkOutput("litDoneAfterWr", 0, 32'(doneCyc[0] - lastWr[0]), 32'd1);
        checkOutput("litBusyLen", 0, 32'(busyCnt[0]), 32'd20);
        checkOutput("litDoneCyc", 0, 32'(doneCyc[0] - t0), 32'd21);
        checkOutput("litDoneCount", 0, 32'(doneCnt[0]), 32'd1);

        // Frame 2 on A: fresh start, 3-cycle stall at read 5.
        clearLogs(0);
        t0 = cyc;
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 5);
        stallS[0] = 1'b1;
        @(negedge clk);
        checkOutput("litStallRdAddr", 0, aRdAddr[0], 32'(expRd[5]));
        checkOutput("litStallRdV", 0, 32'(aRdV[0]), 32'd0);
        checkOutput("litStallEn", 0, 32'(pipeEnA), 32'd0);
        checkOutput("litStallBusy", 0, 32'(busyA), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        stallS[0] = 1'b0;
        waitDone(0, 60);
        checkOutput("litStallRdCount", 0, 32'(rdLogA.size()), 32'd16);
        if (rdLogA.size() >= 7) begin
            checkOutput("litRestart0", 0, 32'(rdLogA[0]), 32'd0);
            checkOutput("litResume5", 0, 32'(rdLogA[5]), 32'(expRd[5]));
            checkOutput("litResume6", 0, 32'(rdLogA[6]), 32'(expRd[6]));
        end
        checkOutput("litStallBusyLen", 0, 32'(busyCnt[0]), 32'd23);
        checkOutput("litStallDoneCyc", 0, 32'(doneCyc[0] - t0), 32'd24);

        // Frame 3 on A: reset (with a coincident start) at read 9.
        clearLogs(0);
        doneBefore = doneCnt[0];
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 9);
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 1);
        startS[0] = 1'b0;
        rstS[0]   = 1'b0;
        @(negedge clk);
        checkOutput("litAbortBusy", 0, 32'(busyA), 32'd0);
        checkOutput("litAbortRdV", 0, 32'(aRdV[0]), 32'd0);
        checkOutput("litAbortRdAddr", 0, aRdAddr[0], 32'd0);
        checkOutput("litAbortPhase", 0, aPhase[0], 32'd0);
        @(posedge clk);
        #1;
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 4);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 36);
        checkOutput("litAbortNoDone", 0, 32'(doneCnt[0] - doneBefore), 32'd0);
        checkOutput("litAbortReads", 0, 32'(rdLogA.size()), 32'd10);
        checkOutput("litAbortBusyLen", 0, 32'(busyCnt[0]), 32'd10);

        // Frame on B: 32 rows through a 4-bit address.
        clearLogs(1);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 1);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 1);
        waitDone(1, 100);
        checkOutput("litBRdCount", 1, 32'(rdLogB.size()), 32'd32);
        if (rdLogB.size() >= 17) begin
            checkOutput("litBRow16", 1, 32'(rdLogB[15]), 32'(exp15B));
            checkOutput("litBRow17", 1, 32'(rdLogB[16]), 32'(exp16B));
        end
        checkOutput("litBWrLatency", 1, 32'(firstWr[1] - firstRd[1]), 32'd3);
        checkOutput("litBBusyLen", 1, 32'(busyCnt[1]), 32'd35);

        repeat (3) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
